// File: rtl/simd_regfile_pkg.sv
// Shared lane/group constants and the lane write-mask helper for the SIMD FP register file.
// Lane index is addr[1:0], group index is addr[4:2].
package simd_regfile_pkg;

  localparam int simd_lanes_gp      = 4;
  localparam int simd_group_bits_gp = 3;
  localparam int simd_addr_bits_gp  = 5;

  function automatic logic [simd_lanes_gp-1:0] lane_mask(input logic simd, input logic [1:0] lane);
    logic [simd_lanes_gp-1:0] one;
    one = 4'b0001;
    return simd ? {simd_lanes_gp{1'b1}} : (one << lane);
  endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO, registered head (no enqueue->dequeue bypass), latency 1.
// ready_o is ~full only; a same-cycle dequeue does not free a slot for the producer until the next cycle.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [1:0][width_p-1:0] mem;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic                    enq;
  logic                    deq;

  assign ready_o = (count != 2'd2);
  assign v_o     = (count != 2'd0);
  assign data_o  = mem[rd_ptr];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/simd_regfile_wb_arbiter.sv
// Writeback arbiter: FPU path is combinational (latency 0), remote loads buffered 2-deep (latency >=1).
// FPU is only stalled when the buffered remote load has lost starve_limit_p arbitrations; rl_ready_o = ~full.
module simd_regfile_wb_arbiter
  import simd_regfile_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int els_p          = 32,
  parameter int starve_limit_p = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  fpu_v_i,
  input  logic                                  fpu_simd_i,
  input  logic [4:0]                            fpu_addr_i,
  input  logic [simd_lanes_gp-1:0][width_p-1:0] fpu_data_i,
  output logic                                  fpu_ready_o,
  input  logic                                  rl_v_i,
  input  logic [4:0]                            rl_addr_i,
  input  logic [width_p-1:0]                    rl_data_i,
  output logic                                  rl_ready_o,
  output logic [simd_lanes_gp-1:0]              w_v_o,
  output logic [4:0]                            w_addr_o,
  output logic [simd_lanes_gp-1:0][width_p-1:0] w_data_o,
  output logic                                  busy_o
);

  localparam int cnt_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_w_lp-1:0] limit_lp = cnt_w_lp'(starve_limit_p);

  typedef struct packed {
    logic [4:0]         addr;
    logic [width_p-1:0] data;
  } rl_entry_s;

  rl_entry_s                head;
  logic                     fifo_v;
  logic                     fifo_ready;
  logic                     head_v;
  logic                     deq;
  logic                     lose;
  logic                     starved;
  logic                     merge;
  logic [simd_lanes_gp-1:0] fpu_mask;
  logic [simd_lanes_gp-1:0] rl_mask;
  logic [cnt_w_lp-1:0]      starve_cnt;

  bsg_two_fifo #(.width_p($bits(rl_entry_s))) rl_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (rl_v_i & ~reset_i),
    .data_i  ({rl_addr_i, rl_data_i}),
    .ready_o (fifo_ready),
    .v_o     (fifo_v),
    .data_o  (head),
    .yumi_i  (deq)
  );

  // During the reset cycle the FIFO may still hold stale entries; hide them.
  assign head_v      = fifo_v & ~reset_i;
  assign busy_o      = head_v;
  assign rl_ready_o  = fifo_ready | reset_i;
  assign starved     = head_v & (starve_cnt == limit_lp);
  assign fpu_ready_o = ~starved;

  assign fpu_mask = lane_mask(fpu_simd_i, fpu_addr_i[1:0]);
  assign rl_mask  = lane_mask(1'b0, head.addr[1:0]);
  assign merge    = fpu_v_i & head_v & ~starved
                  & (fpu_addr_i[4:2] == head.addr[4:2])
                  & ((fpu_mask & rl_mask) == '0);

  always_comb begin
    w_v_o    = '0;
    w_addr_o = fpu_addr_i;
    w_data_o = fpu_data_i;
    deq      = 1'b0;
    lose     = 1'b0;
    if (reset_i) begin
      w_v_o = '0;
    end else if (starved) begin
      w_v_o    = rl_mask;
      w_addr_o = head.addr;
      w_data_o = {simd_lanes_gp{head.data}};
      deq      = 1'b1;
    end else if (merge) begin
      w_v_o = fpu_mask | rl_mask;
      for (int i = 0; i < simd_lanes_gp; i++) begin
        if (rl_mask[i]) w_data_o[i] = head.data;
      end
      deq = 1'b1;
    end else if (fpu_v_i) begin
      w_v_o = fpu_mask;
      lose  = head_v;
    end else if (head_v) begin
      w_v_o    = rl_mask;
      w_addr_o = head.addr;
      w_data_o = {simd_lanes_gp{head.data}};
      deq      = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || !head_v || deq) begin
      starve_cnt <= '0;
    end else if (lose && (starve_cnt != limit_lp)) begin
      starve_cnt <= starve_cnt + cnt_w_lp'(1);
    end
  end

endmodule

// File: doc/simd_regfile_wb_arbiter.md
# simd_regfile_wb_arbiter

Writeback arbiter and sequencer for the four-lane SIMD FP register file. It sits between the two writeback sources and the register file's single write-group port. The sources are the FPU pipeline, which writes either one scalar lane or all four lanes of a group, and remote-load returns, which are scalar only. It buffers remote loads, merges compatible writes into one cycle, and prevents the remote-load path from starving.

## Interface
- width_p, none (required), lane data width (FP register width)
- els_p, 32, register count; must be 32 (8 groups × 4 lanes)
- starve_limit_p, 4, cycles a buffered remote load may lose arbitration before it is forced through; must be ≥1
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset; one clock
- fpu_v_i  in  1  FPU writeback valid
- fpu_simd_i  in  1  1: write all 4 lanes of group fpu_addr_i[4:2]; 0: scalar write of lane fpu_addr_i[1:0]
- fpu_addr_i  in  5  FPU destination register
- fpu_data_i  in  4×width_p  lane i data; scalar writes use lane fpu_addr_i[1:0]
- fpu_ready_o  out  1  FPU write accepted this cycle when fpu_v_i & fpu_ready_o
- rl_v_i  in  1  remote-load return valid
- rl_addr_i  in  5  remote-load destination register
- rl_data_i  in  width_p  remote-load data
- rl_ready_o  out  1  buffer can accept; transfer on rl_v_i & rl_ready_o
- w_v_o  out  4  per-lane write enable to register file
- w_addr_o  out  5  write address; only bits [4:2] are meaningful to the register file
- w_data_o  out  4×width_p  per-lane write data
- busy_o  out  1  remote-load buffer non-empty

## Operation
- Remote-load buffer: 2-entry FIFO. Enqueue on rl_v_i & rl_ready_o. rl_ready_o = ~full; it does not depend on a same-cycle dequeue. No bypass: an enqueued entry is first visible at the FIFO head on the next cycle.
- Lane masks:
  - FPU mask = fpu_simd_i ? 4'b1111 : onehot(fpu_addr_i[1:0]).
  - Remote-load head mask = onehot(head.addr[1:0]).
- starved = head valid & (starve_cnt == starve_limit_p).
- fpu_ready_o = ~starved. It does not depend on fpu_v_i.
- Grant rules, evaluated each cycle:
  - Starved: the head writes alone and dequeues. w_v_o = head mask; w_addr_o = head.addr.
  - Merge: fpu_v_i & head valid & ~starved & same group ([4:2] equal) & disjoint masks. Both retire. w_v_o = FPU mask | head mask. Each lane's data comes from its owner. w_addr_o = fpu_addr_i.
  - FPU wins: fpu_v_i & ~starved, no merge. w_v_o = FPU mask. The head stays.
  - Remote load alone: ~fpu_v_i & head valid. The head writes and dequeues.
  - Idle: w_v_o = 0.
- Remote-load data is steered to lane head.addr[1:0]. All other lanes of w_data_o are don't-care but must be driven: replicate the data.
- Same-register conflict (same group, overlapping lane): no merge. The FPU writes first and the remote load writes on a later cycle, so the remote value is final. This is decided; software/scoreboard owns ordering.
- starve_cnt, width clog2(starve_limit_p+1):
  - Clears when the head dequeues or the FIFO is empty.
  - Otherwise increments when the head is valid and loses arbitration.
  - Saturates at starve_limit_p.
- busy_o = FIFO non-empty.

## Timing
- FPU path: latency 0. Write outputs are combinational from fpu_* inputs and commit at the next clk_i edge.
- Remote-load path: minimum latency 1 (enqueue edge, then write on the following cycle). A forced write occurs at most starve_limit_p+1 cycles after the entry reaches the head.
- Reset (and the cycle it is asserted):
  - FIFO empty, starve_cnt = 0.
  - w_v_o = 0 and busy_o = 0.
  - fpu_ready_o = 1 and rl_ready_o = 1.
  - Inputs are ignored; no enqueue occurs.
- Reset mid-operation: buffered remote loads are discarded and are not written.
- Full FIFO with simultaneous dequeue: rl_ready_o stays 0 that cycle. The freed slot is offered on the next cycle.

## Structure
- Package simd_regfile_pkg:
  - rl_entry_s {addr[4:0], data[width_p]}, parameterized via width.
  - Constants: simd_lanes_gp = 4, simd_group_bits_gp = 3.
  - Function lane_mask(simd, lane).
- Sub-module: bsg_two_fifo holds the remote-load buffer. Arbitration, merge and the counter are flat in this module.
- Expected size: ~150–200 lines.

## Test plan
- Reset, then rl enqueue of addr 5'd6, data A, with no FPU traffic → next cycle w_v_o = 4'b0100, w_addr_o[4:2] = 1, w_data_o[2] = A; busy_o falls the cycle after.
- FPU scalar addr 5'd8 and buffered rl addr 5'd9, same cycle → merge: w_v_o = 4'b0011, lane0 = FPU data, lane1 = rl data; FIFO empties.
- FPU SIMD addr 5'd12 every cycle and rl addr 5'd13 buffered, starve_limit_p = 4 → FPU granted for 4 cycles. On the 5th cycle fpu_ready_o = 0 and w_v_o = 4'b0010 (rl); starve_cnt returns to 0.
- Two rl enqueues with FPU held busy → rl_ready_o = 0 after the 2nd. A 3rd rl_v_i is not accepted until the cycle after the first dequeue.
- FPU scalar addr 5'd3 and rl addr 5'd3 buffered, same cycle → FPU writes lane3 first; rl writes lane3 on the next FPU-idle (or forced) cycle, so the final value is rl data.
- Reset asserted with 2 entries buffered → w_v_o = 0 during reset and no rl writes after release; busy_o = 0 and rl_ready_o = 1.
